// File: rtl/a2p_wb_arbiter.sv
// a2p_wb_arbiter
//   Merges the A2P instruction (wb_i) and data (wb_d) Wishbone masters onto one
//   shared Wishbone slave port (wb_s). Round-robin arbitration between the two
//   masters. A grant is held for the whole CYC, so bursts and read-modify-write
//   sequences stay atomic. A per-transfer ACK timeout returns ERR to the granted
//   master.
//
// Parameters
//   TIMEOUT : cycles a strobe may wait for ACK/ERR before ERR is forced (>= 2)
//   TRACE   : kept so existing instantiations still elaborate; this block emits
//             no trace output
//
// Ports
//   clk, reset          : rising-edge clock, asynchronous active-high reset
//   wb_i_*              : instruction master (read-only), ACK/ERR/DAT_MISO back
//   wb_d_*              : data master, ACK/ERR/DAT_MISO back
//   wb_s_*              : shared slave port toward memory/SoC
//   grant               : one-hot {d,i}; 00 = idle
module a2p_wb_arbiter #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned TRACE   = 0
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        wb_i_CYC,
  input  logic        wb_i_STB,
  input  logic [29:0] wb_i_ADR,
  input  logic [2:0]  wb_i_CTI,
  input  logic [1:0]  wb_i_BTE,
  output logic        wb_i_ACK,
  output logic        wb_i_ERR,
  output logic [31:0] wb_i_DAT_MISO,

  input  logic        wb_d_CYC,
  input  logic        wb_d_STB,
  input  logic        wb_d_WE,
  input  logic [29:0] wb_d_ADR,
  input  logic [3:0]  wb_d_SEL,
  input  logic [31:0] wb_d_DAT_MOSI,
  input  logic [2:0]  wb_d_CTI,
  input  logic [1:0]  wb_d_BTE,
  output logic        wb_d_ACK,
  output logic        wb_d_ERR,
  output logic [31:0] wb_d_DAT_MISO,

  output logic        wb_s_CYC,
  output logic        wb_s_STB,
  output logic        wb_s_WE,
  output logic [29:0] wb_s_ADR,
  output logic [3:0]  wb_s_SEL,
  output logic [31:0] wb_s_DAT_MOSI,
  output logic [2:0]  wb_s_CTI,
  output logic [1:0]  wb_s_BTE,
  input  logic        wb_s_ACK,
  input  logic        wb_s_ERR,
  input  logic [31:0] wb_s_DAT_MISO,

  output logic [1:0]  grant
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t        state, state_next;
  logic          last_d, last_d_next;   // 1: D held the most recent grant
  logic [CW-1:0] to_cnt, to_cnt_next;
  logic          m_cyc, m_stb;
  logic          timeout;

  // Grant-change tracing belongs to the simulation environment.
  if (TRACE != 0) begin : g_trace
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      last_d <= 1'b1;
      to_cnt <= '0;
    end else begin
      state  <= state_next;
      last_d <= last_d_next;
      to_cnt <= to_cnt_next;
    end
  end

  // Request of whichever master currently owns the slave port.
  always_comb begin
    m_cyc = 1'b0;
    m_stb = 1'b0;
    case (state)
      GNT_I: begin
        m_cyc = wb_i_CYC;
        m_stb = wb_i_CYC & wb_i_STB;
      end
      GNT_D: begin
        m_cyc = wb_d_CYC;
        m_stb = wb_d_CYC & wb_d_STB;
      end
      default: ;
    endcase
  end

  assign timeout = m_stb && (to_cnt == TO_LAST);

  always_comb begin
    state_next  = state;
    last_d_next = last_d;
    case (state)
      IDLE: begin
        if (wb_i_CYC && (!wb_d_CYC || last_d)) begin
          state_next  = GNT_I;
          last_d_next = 1'b0;
        end else if (wb_d_CYC) begin
          state_next  = GNT_D;
          last_d_next = 1'b1;
        end
      end
      GNT_I, GNT_D: begin
        if (!m_cyc || timeout) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (!m_stb || wb_s_ACK || wb_s_ERR || timeout) to_cnt_next = '0;
    else                                           to_cnt_next = to_cnt + CW'(1);
  end

  // Slave-side mux and response routing. On the timeout cycle the slave sees
  // no strobe, the owner sees ERR, and any coincident slave ACK is swallowed.
  always_comb begin
    wb_s_CYC      = 1'b0;
    wb_s_STB      = 1'b0;
    wb_s_WE       = 1'b0;
    wb_s_ADR      = '0;
    wb_s_SEL      = '0;
    wb_s_DAT_MOSI = '0;
    wb_s_CTI      = '0;
    wb_s_BTE      = '0;
    wb_i_ACK      = 1'b0;
    wb_i_ERR      = 1'b0;
    wb_d_ACK      = 1'b0;
    wb_d_ERR      = 1'b0;
    case (state)
      GNT_I: begin
        wb_s_CYC = wb_i_CYC & ~timeout;
        wb_s_STB = wb_i_STB & ~timeout;
        wb_s_ADR = wb_i_ADR;
        wb_s_SEL = '1;
        wb_s_CTI = wb_i_CTI;
        wb_s_BTE = wb_i_BTE;
        wb_i_ACK = wb_s_ACK & ~wb_s_ERR & ~timeout;
        wb_i_ERR = wb_s_ERR | timeout;
      end
      GNT_D: begin
        wb_s_CYC      = wb_d_CYC & ~timeout;
        wb_s_STB      = wb_d_STB & ~timeout;
        wb_s_WE       = wb_d_WE;
        wb_s_ADR      = wb_d_ADR;
        wb_s_SEL      = wb_d_SEL;
        wb_s_DAT_MOSI = wb_d_DAT_MOSI;
        wb_s_CTI      = wb_d_CTI;
        wb_s_BTE      = wb_d_BTE;
        wb_d_ACK      = wb_s_ACK & ~wb_s_ERR & ~timeout;
        wb_d_ERR      = wb_s_ERR | timeout;
      end
      default: ;
    endcase
  end

  assign wb_i_DAT_MISO = wb_s_DAT_MISO;
  assign wb_d_DAT_MISO = wb_s_DAT_MISO;
  assign grant         = {state == GNT_D, state == GNT_I};

endmodule
